// File: rtl/ma_pkg.sv
// Shared types for the memory-access stage.
// State enum, size codes and the latched request bundle.
package ma_pkg;
  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    size_t           size;
    logic            uns;
    logic            we;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
  } req_t;

  function automatic logic misaligned(
    input size_t      sz,
    input logic [2:0] a
  );
    logic m;
    m = 1'b0;
    unique case (sz)
      SZ_B: m = 1'b0;
      SZ_H: m = a[0];
      SZ_W: m = |a[1:0];
      SZ_D: m = |a[2:0];
    endcase
    return m;
  endfunction
endpackage

// File: rtl/ma_lane.sv
// Byte-lane steering: store strobes/replication
// and load extraction with sign/zero extension.
module ma_lane
  import ma_pkg::*;
(
  input  logic [2:0]      addr_lo,
  input  size_t           size,
  input  logic            uns,
  input  logic [XLEN-1:0] data,
  input  logic [XLEN-1:0] rdata,
  output logic [7:0]      wstrb,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] ldata
);
  logic [XLEN-1:0] sh;

  assign sh = rdata >> {addr_lo, 3'b000};

  always_comb begin
    wstrb = 8'h00;
    wdata = '0;
    ldata = '0;
    unique case (size)
      SZ_B: begin
        wstrb = 8'h01 << addr_lo;
        wdata = {8{data[7:0]}};
        ldata = uns ? {56'b0, sh[7:0]}
                    : {{56{sh[7]}}, sh[7:0]};
      end
      SZ_H: begin
        wstrb = 8'h03 << addr_lo;
        wdata = {4{data[15:0]}};
        ldata = uns ? {48'b0, sh[15:0]}
                    : {{48{sh[15]}}, sh[15:0]};
      end
      SZ_W: begin
        wstrb = 8'h0F << addr_lo;
        wdata = {2{data[31:0]}};
        ldata = uns ? {32'b0, sh[31:0]}
                    : {{32{sh[31]}}, sh[31:0]};
      end
      SZ_D: begin
        wstrb = 8'hFF;
        wdata = data;
        ldata = sh;
      end
    endcase
  end
endmodule

// File: rtl/mem_access.sv
// Memory-access stage: single-outstanding bus
// master with flush draining and misalign traps.
module mem_access
  import ma_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            in_valid,
  input  logic [XLEN-1:0] pc_in,
  input  logic [4:0]      rd_in,
  input  logic [XLEN-1:0] result_in,
  input  logic [XLEN-1:0] data2_in,
  input  logic            ld_op,
  input  logic            st_op,
  input  logic [1:0]      size,
  input  logic            uns,
  output logic            stall_req,
  output logic            bus_req_valid,
  input  logic            bus_req_ready,
  output logic [XLEN-1:0] bus_addr,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_wdata,
  output logic [7:0]      bus_wstrb,
  input  logic            bus_rsp_valid,
  input  logic [XLEN-1:0] bus_rdata,
  output logic            misalign_en,
  output logic [XLEN-1:0] misalign_addr,
  output logic            valid_out,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] data_out
);
  state_t state, state_n;
  req_t   r;

  logic            live;
  logic            is_mem;
  logic            mis;
  logic            issue;
  logic            trap;
  logic            alu;
  logic            done;
  logic [XLEN-1:0] ldata;

  assign live   = (state == IDLE) && in_valid && !clear;
  assign is_mem = ld_op || st_op;
  assign mis    = misaligned(size_t'(size), result_in[2:0]);
  assign issue  = live && is_mem && !mis;
  assign trap   = live && is_mem && mis;
  assign alu    = live && !is_mem;
  assign done   = (state == WAIT) && bus_rsp_valid && !clear;

  assign bus_addr = {r.addr[XLEN-1:3], 3'b000};
  assign bus_we   = r.we;

  ma_lane u_lane (
    .addr_lo (r.addr[2:0]),
    .size    (r.size),
    .uns     (r.uns),
    .data    (r.data),
    .rdata   (bus_rdata),
    .wstrb   (bus_wstrb),
    .wdata   (bus_wdata),
    .ldata   (ldata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    stall_req     = 1'b0;
    bus_req_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (issue) begin
          state_n   = REQ;
          stall_req = 1'b1;
        end
      end
      REQ: begin
        bus_req_valid = 1'b1;
        stall_req     = 1'b1;
        if (clear)
          state_n = bus_req_ready ? DRAIN : IDLE;
        else if (bus_req_ready)
          state_n = WAIT;
      end
      WAIT: begin
        // A response racing the flush retires the slot directly.
        stall_req = !bus_rsp_valid;
        if (bus_rsp_valid) state_n = IDLE;
        else if (clear)    state_n = DRAIN;
      end
      DRAIN: begin
        stall_req = 1'b1;
        if (bus_rsp_valid) state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r             <= '0;
      misalign_en   <= 1'b0;
      misalign_addr <= '0;
      valid_out     <= 1'b0;
      pc_out        <= '0;
      rd_out        <= '0;
      data_out      <= '0;
    end else begin
      misalign_en <= trap;
      if (trap) misalign_addr <= result_in;
      if (issue) begin
        r.addr <= result_in;
        r.data <= data2_in;
        r.size <= size_t'(size);
        r.uns  <= uns;
        r.we   <= st_op;
        r.pc   <= pc_in;
        r.rd   <= rd_in;
      end
      valid_out <= alu || done;
      if (alu) begin
        pc_out   <= pc_in;
        rd_out   <= rd_in;
        data_out <= result_in;
      end else if (done) begin
        pc_out   <= r.pc;
        rd_out   <= r.we ? 5'd0 : r.rd;
        data_out <= r.we ? '0 : ldata;
      end else begin
        rd_out <= 5'd0;
      end
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access.
// Hand-computed expectations checked by assertions.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic [63:0] pc_in;
  logic [4:0]  rd_in;
  logic [63:0] result_in;
  logic [63:0] data2_in;
  logic        ld_op;
  logic        st_op;
  logic [1:0]  size;
  logic        uns;
  logic        stall_req;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [63:0] bus_addr;
  logic        bus_we;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        bus_rsp_valid;
  logic [63:0] bus_rdata;
  logic        misalign_en;
  logic [63:0] misalign_addr;
  logic        valid_out;
  logic [63:0] pc_out;
  logic [4:0]  rd_out;
  logic [63:0] data_out;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .in_valid      (in_valid),
    .pc_in         (pc_in),
    .rd_in         (rd_in),
    .result_in     (result_in),
    .data2_in      (data2_in),
    .ld_op         (ld_op),
    .st_op         (st_op),
    .size          (size),
    .uns           (uns),
    .stall_req     (stall_req),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_addr      (bus_addr),
    .bus_we        (bus_we),
    .bus_wdata     (bus_wdata),
    .bus_wstrb     (bus_wstrb),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rdata     (bus_rdata),
    .misalign_en   (misalign_en),
    .misalign_addr (misalign_addr),
    .valid_out     (valid_out),
    .pc_out        (pc_out),
    .rd_out        (rd_out),
    .data_out      (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    clear         = 1'b0;
    in_valid      = 1'b0;
    pc_in         = '0;
    rd_in         = '0;
    result_in     = '0;
    data2_in      = '0;
    ld_op         = 1'b0;
    st_op         = 1'b0;
    size          = 2'd0;
    uns           = 1'b0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rdata     = '0;
  endtask

  task automatic mem(input logic ld, input logic [1:0] sz,
                     input logic [63:0] a, input logic [63:0] d,
                     input logic [4:0] rd);
    in_valid  = 1'b1;
    ld_op     = ld;
    st_op     = !ld;
    size      = sz;
    uns       = 1'b0;
    result_in = a;
    data2_in  = d;
    rd_in     = rd;
    pc_in     = 64'h400;
  endtask

  initial begin
    quiet();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_stall", 64'(stall_req), 64'd0);
    chk("rst_breq", 64'(bus_req_valid), 64'd0);
    chk("rst_mis", 64'(misalign_en), 64'd0);
    chk("rst_rd", 64'(rd_out), 64'd0);

    // ADD
    in_valid = 1'b1; rd_in = 5'd3;
    pc_in = 64'h100; result_in = 64'h5;
    #1 chk("add_stall", 64'(stall_req), 64'd0);
    tick(); quiet();
    chk("add_valid", 64'(valid_out), 64'd1);
    chk("add_data", data_out, 64'h5);
    chk("add_rd", 64'(rd_out), 64'd3);
    chk("add_pc", pc_out, 64'h100);
    tick();
    chk("add_bubble_rd", 64'(rd_out), 64'd0);

    // LB signed
    mem(1'b1, 2'd0, 64'h1003, 64'h0, 5'd5);
    #1 chk("lb_stall_issue", 64'(stall_req), 64'd1);
    tick(); quiet(); bus_req_ready = 1'b1;
    #1;
    chk("lb_breq", 64'(bus_req_valid), 64'd1);
    chk("lb_addr", bus_addr, 64'h1000);
    chk("lb_we", 64'(bus_we), 64'd0);
    chk("lb_stall_req", 64'(stall_req), 64'd1);
    tick(); bus_req_ready = 1'b0;
    #1;
    chk("lb_stall_wait", 64'(stall_req), 64'd1);
    chk("lb_breq_wait", 64'(bus_req_valid), 64'd0);
    tick(); bus_rsp_valid = 1'b1;
    bus_rdata = 64'h00000000_80000000;
    #1 chk("lb_stall_rsp", 64'(stall_req), 64'd0);
    tick(); quiet();
    chk("lb_valid", 64'(valid_out), 64'd1);
    chk("lb_data", data_out, 64'hFFFFFFFF_FFFFFF80);
    chk("lb_rd", 64'(rd_out), 64'd5);

    // SH
    mem(1'b0, 2'd1, 64'h2006, 64'hBEEF, 5'd7);
    tick(); quiet(); bus_req_ready = 1'b1;
    #1;
    chk("sh_strb", 64'(bus_wstrb), 64'hC0);
    chk("sh_addr", bus_addr, 64'h2000);
    chk("sh_wdata", bus_wdata, 64'hBEEFBEEF_BEEFBEEF);
    chk("sh_we", 64'(bus_we), 64'd1);
    tick(); bus_req_ready = 1'b0; bus_rsp_valid = 1'b1;
    tick(); quiet();
    chk("sh_valid", 64'(valid_out), 64'd1);
    chk("sh_rd", 64'(rd_out), 64'd0);

    // LW misaligned
    mem(1'b1, 2'd2, 64'h3002, 64'h0, 5'd8);
    #1 chk("lw_stall", 64'(stall_req), 64'd0);
    tick(); quiet();
    chk("lw_mis_en", 64'(misalign_en), 64'd1);
    chk("lw_mis_addr", misalign_addr, 64'h3002);
    chk("lw_breq", 64'(bus_req_valid), 64'd0);
    chk("lw_valid", 64'(valid_out), 64'd0);
    tick();
    chk("lw_mis_pulse", 64'(misalign_en), 64'd0);
    chk("lw_breq2", 64'(bus_req_valid), 64'd0);

    // LD with ready held low 3 cycles
    mem(1'b1, 2'd3, 64'h4000, 64'h0, 5'd9);
    tick(); quiet();
    for (int i = 0; i < 4; i++) begin
      bus_req_ready = (i == 3);
      #1;
      chk($sformatf("ld_breq%0d", i), 64'(bus_req_valid), 64'd1);
      chk($sformatf("ld_addr%0d", i), bus_addr, 64'h4000);
      chk($sformatf("ld_stall%0d", i), 64'(stall_req), 64'd1);
      tick();
    end
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b1;
    bus_rdata = 64'h11223344_55667788;
    tick(); quiet();
    chk("ld_valid", 64'(valid_out), 64'd1);
    chk("ld_data", data_out, 64'h11223344_55667788);
    chk("ld_rd", 64'(rd_out), 64'd9);

    // LD, clear in WAIT, response two cycles later
    mem(1'b1, 2'd3, 64'h5000, 64'h0, 5'd4);
    tick(); quiet(); bus_req_ready = 1'b1;
    tick(); bus_req_ready = 1'b0; clear = 1'b1;
    #1 chk("dr_stall_clr", 64'(stall_req), 64'd1);
    tick(); clear = 1'b0;
    #1;
    chk("dr_stall", 64'(stall_req), 64'd1);
    chk("dr_valid", 64'(valid_out), 64'd0);
    tick(); bus_rsp_valid = 1'b1; bus_rdata = 64'hDEAD;
    #1 chk("dr_stall_rsp", 64'(stall_req), 64'd1);
    tick(); quiet();
    chk("dr_stall_after", 64'(stall_req), 64'd0);
    chk("dr_valid_after", 64'(valid_out), 64'd0);
    chk("dr_rd_after", 64'(rd_out), 64'd0);

    // Clear in REQ before handshake
    mem(1'b1, 2'd3, 64'h6000, 64'h0, 5'd2);
    tick(); quiet(); clear = 1'b1;
    tick(); clear = 1'b0;
    #1;
    chk("cr_breq", 64'(bus_req_valid), 64'd0);
    chk("cr_stall", 64'(stall_req), 64'd0);
    chk("cr_valid", 64'(valid_out), 64'd0);

    // Reset during WAIT, then stale response
    mem(1'b1, 2'd3, 64'h7000, 64'h0, 5'd6);
    tick(); quiet(); bus_req_ready = 1'b1;
    tick(); bus_req_ready = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0;
    chk("rw_stall", 64'(stall_req), 64'd0);
    chk("rw_valid", 64'(valid_out), 64'd0);
    chk("rw_breq", 64'(bus_req_valid), 64'd0);
    chk("rw_addr", bus_addr, 64'd0);
    chk("rw_data", data_out, 64'd0);
    chk("rw_pc", pc_out, 64'd0);
    chk("rw_rd", 64'(rd_out), 64'd0);
    bus_rsp_valid = 1'b1; bus_rdata = 64'h1234;
    tick(); quiet();
    chk("stale_valid", 64'(valid_out), 64'd0);
    chk("stale_stall", 64'(stall_req), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk, rst.
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  clear  in  1  flush; discard current instruction
  in_valid  in  1  EX/MA register holds an instruction
  pc_in  in  64  instruction PC
  rd_in  in  5  destination register, 0 = none
  result_in  in  64  ALU result, or effective address for memory ops
  data2_in  in  64  store data
  ld_op, st_op  in  1 each  load / store
  size  in  2  0=B 1=H 2=W 3=D
  uns  in  1  zero-extend load
  stall_req  out  1  freeze upstream stages
  bus_req_valid  out  1  bus request
  bus_req_ready  in  1  bus accepts request
  bus_addr  out  64  8-byte-aligned address
  bus_we  out  1  write
  bus_wdata  out  64  lane-replicated store data
  bus_wstrb  out  8  byte enables
  bus_rsp_valid  in  1  read data / write ack
  bus_rdata  in  64  read data
  misalign_en  out  1  misaligned-access trap pulse
  misalign_addr  out  64  faulting address
  valid_out, pc_out, rd_out, data_out  out  1/64/5/64  MA/WB register
REQ-003 Parameters SHALL be none; widths SHALL be fixed at XLEN=64.

Function
REQ-004 FSM states SHALL be IDLE, REQ, WAIT, DRAIN.
REQ-005 In IDLE, for a non-memory instruction, the block SHALL register pc_in, rd_in and result_in into the MA/WB register with 1-cycle latency and SHALL keep stall_req=0.
REQ-006 In IDLE, for an aligned memory op, the block SHALL latch the address, data, size, uns, pc and rd, move to REQ, and assert stall_req combinationally in that same cycle.
REQ-007 stall_req SHALL stay high in REQ and WAIT and SHALL drop in the cycle bus_rsp_valid is seen in WAIT.
REQ-008 In REQ, bus_req_valid SHALL be 1 and all bus outputs SHALL be stable; on bus_req_ready=1 the block SHALL move to WAIT.
REQ-009 In WAIT, on bus_rsp_valid=1 the block SHALL write the MA/WB register (loads: extended data; stores: rd_out=0) and return to IDLE.
REQ-010 Alignment: the block SHALL flag misalignment when addr[0]!=0 (H), addr[1:0]!=0 (W) or addr[2:0]!=0 (D); a misaligned op SHALL issue no bus request, SHALL pulse misalign_en for 1 cycle with misalign_addr, and SHALL produce valid_out=0.
REQ-011 bus_addr SHALL be {addr[63:3],3'b0}.
REQ-012 bus_wstrb SHALL be 0x01/0x03/0x0F/0xFF shifted left by addr[2:0] for B/H/W/D.
REQ-013 bus_wdata SHALL replicate the low data bytes across all lanes.
REQ-014 Load data SHALL be bus_rdata shifted right by 8*addr[2:0], truncated to size, then sign- or zero-extended per uns.
REQ-015 On clear in IDLE, the block SHALL drop the input instruction; on clear in REQ before the handshake, it SHALL return to IDLE with no bus request.
REQ-016 On clear in REQ with handshake in the same cycle, or clear in WAIT, the block SHALL enter DRAIN.
REQ-017 DRAIN SHALL consume one bus_rsp_valid, discard the data, and return to IDLE; stall_req SHALL be 1 in DRAIN.
REQ-018 When valid_out=0, rd_out SHALL be 0 so that writeback never writes.
REQ-019 The block SHALL have at most one outstanding bus transaction.

Reset
REQ-020 rst SHALL take precedence over clear, SHALL force IDLE, and SHALL zero every output and register, including bus_req_valid, stall_req, misalign_en and valid_out.
REQ-021 A reset asserted during WAIT or DRAIN SHALL abandon the transaction; a stale bus_rsp_valid after reset SHALL be ignored in IDLE.

Structure
REQ-022 The FSM state enum, the size encodings and the XLEN constant SHALL live in the shared package ma_pkg.
REQ-023 Load extraction/extension and strobe/wdata generation SHALL be one combinational sub-module, ma_lane.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
  - LB, addr=0x1003, uns=0, rdata=0x00000000_80000000 -> data_out=0xFFFFFFFF_FFFFFF80, stall_req high from issue until the rsp cycle.
  - SH, addr=0x2006, data2=0xBEEF -> bus_wstrb=0xC0, bus_addr=0x2000, bus_wdata=0xBEEFBEEF_BEEFBEEF, rd_out=0.
  - LW, addr=0x3002 -> misalign_en=1 for 1 cycle, misalign_addr=0x3002, no bus_req_valid, valid_out=0.
  - LD with bus_req_ready held low 3 cycles -> bus_req_valid and bus_addr stable for 4 cycles, stall_req stays 1.
  - LD, then clear in WAIT, rsp arrives 2 cycles later -> DRAIN, valid_out=0, stall_req drops after the rsp.
  - ADD, result=0x5 -> next cycle valid_out=1, data_out=0x5, stall_req=0; rst during WAIT -> IDLE and all outputs 0 next cycle.
